// File: rtl/inst_seq_ctrl.sv
// Multi-cycle instruction sequencer: accepts one instruction per fetch handshake, selects the
// immediate format, runs OP-FP through the FPU handshake with a timeout, and pulses writebacks.
module inst_seq_ctrl #(
   parameter int unsigned FPU_TIMEOUT = 64,
   parameter int unsigned CNT_W       = 7
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        inst_valid_i,
   input  logic [31:0] inst_i,
   output logic        inst_ready_o,
   output logic [31:0] inst_o,
   output logic [2:0]  imm_op_o,
   output logic        fpu_req_o,
   output logic [4:0]  fpu_op_o,
   input  logic        fpu_ack_i,
   input  logic        fpu_done_i,
   output logic        rd_we_o,
   output logic        frd_we_o,
   output logic        illegal_o,
   output logic        fpu_timeout_o
);

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_DEC      = 3'd1,
      S_FPU_REQ  = 3'd2,
      S_FPU_WAIT = 3'd3,
      S_WB       = 3'd4
   } state_t;

   localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
   localparam logic [6:0] OPC_LOAD     = 7'b0000011;
   localparam logic [6:0] OPC_JALR     = 7'b1100111;
   localparam logic [6:0] OPC_LOAD_FP  = 7'b0000111;
   localparam logic [6:0] OPC_STORE    = 7'b0100011;
   localparam logic [6:0] OPC_STORE_FP = 7'b0100111;
   localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
   localparam logic [6:0] OPC_LUI      = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
   localparam logic [6:0] OPC_JAL      = 7'b1101111;
   localparam logic [6:0] OPC_OP       = 7'b0110011;
   localparam logic [6:0] OPC_OP_FP    = 7'b1010011;

   localparam logic [2:0] IMM_I = 3'b000;
   localparam logic [2:0] IMM_S = 3'b001;
   localparam logic [2:0] IMM_B = 3'b010;
   localparam logic [2:0] IMM_U = 3'b011;
   localparam logic [2:0] IMM_J = 3'b100;
   localparam logic [2:0] IMM_R = 3'b101;

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FPU_TIMEOUT - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   state_t           r_state;
   state_t           w_next_state;
   logic [31:0]      r_inst;
   logic [2:0]       r_imm_op;
   logic             r_rd_we;
   logic             r_frd_we;
   logic             r_illegal;
   logic             r_timeout;
   logic [CNT_W-1:0] r_cnt;

   logic [6:0]       w_opcode;
   logic [4:0]       w_funct5;
   logic [2:0]       w_imm_dec;
   logic             w_legal;
   logic             w_is_fp;
   logic             w_rd_wr;
   logic             w_frd_wr;
   logic             w_cnt_last;
   logic             w_wb_enter;
   logic             w_expire;

   assign w_opcode   = r_inst[6:0];
   assign w_funct5   = r_inst[31:27];
   assign w_cnt_last = (r_cnt == CNT_LAST);

   // Classification of the latched instruction; consumed in DEC and again on entry to WB.
   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      w_imm_dec = IMM_R;
      w_legal   = 1'b1;
      w_is_fp   = 1'b0;
      w_rd_wr   = 1'b0;
      w_frd_wr  = 1'b0;
      case (w_opcode)
         OPC_OP_IMM, OPC_LOAD, OPC_JALR: begin
            w_imm_dec = IMM_I;
            w_rd_wr   = 1'b1;
         end
         OPC_LOAD_FP: begin
            w_imm_dec = IMM_I;
            w_frd_wr  = 1'b1;
         end
         OPC_STORE, OPC_STORE_FP: w_imm_dec = IMM_S;
         OPC_BRANCH:              w_imm_dec = IMM_B;
         OPC_LUI, OPC_AUIPC: begin
            w_imm_dec = IMM_U;
            w_rd_wr   = 1'b1;
         end
         OPC_JAL: begin
            w_imm_dec = IMM_J;
            w_rd_wr   = 1'b1;
         end
         OPC_OP: w_rd_wr = 1'b1;
         OPC_OP_FP: begin
            w_is_fp = 1'b1;
            case (w_funct5)
               5'b10100, 5'b11000, 5'b11100: w_rd_wr  = 1'b1;
               default:                      w_frd_wr = 1'b1;
            endcase
         end
         default: w_legal = 1'b0;
      endcase
      if (r_inst[11:7] == 5'd0) begin
         w_rd_wr = 1'b0;
      end
   end

   // Completion (done) takes priority over the timeout expiring in the same cycle.
   always_comb begin
      w_next_state = r_state;
      w_wb_enter   = 1'b0;
      w_expire     = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (inst_valid_i) w_next_state = S_DEC;
         end
         S_DEC: begin
            if (!w_legal) begin
               w_next_state = S_IDLE;
            end else if (w_is_fp) begin
               w_next_state = S_FPU_REQ;
            end else begin
               w_next_state = S_WB;
               w_wb_enter   = 1'b1;
            end
         end
         S_FPU_REQ: begin
            if (fpu_ack_i && fpu_done_i) begin
               w_next_state = S_WB;
               w_wb_enter   = 1'b1;
            end else if (w_cnt_last) begin
               w_next_state = S_IDLE;
               w_expire     = 1'b1;
            end else if (fpu_ack_i) begin
               w_next_state = S_FPU_WAIT;
            end
         end
         S_FPU_WAIT: begin
            if (fpu_done_i) begin
               w_next_state = S_WB;
               w_wb_enter   = 1'b1;
            end else if (w_cnt_last) begin
               w_next_state = S_IDLE;
               w_expire     = 1'b1;
            end
         end
         S_WB:    w_next_state = S_IDLE;
         default: w_next_state = S_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_inst    <= 32'd0;
         r_imm_op  <= IMM_R;
         r_cnt     <= '0;
         r_rd_we   <= 1'b0;
         r_frd_we  <= 1'b0;
         r_illegal <= 1'b0;
         r_timeout <= 1'b0;
      end else begin
         if (r_state == S_IDLE && inst_valid_i) begin
            r_inst <= inst_i;
         end
         if (r_state == S_DEC) begin
            r_imm_op <= w_imm_dec;
            r_cnt    <= '0;
         end else if (r_state == S_FPU_REQ || r_state == S_FPU_WAIT) begin
            r_cnt <= r_cnt + CNT_ONE;
         end
         r_rd_we   <= w_wb_enter & w_rd_wr;
         r_frd_we  <= w_wb_enter & w_frd_wr;
         r_illegal <= (r_state == S_DEC) & ~w_legal;
         r_timeout <= w_expire;
      end
   end

   assign inst_ready_o  = (r_state == S_IDLE);
   assign fpu_req_o     = (r_state == S_FPU_REQ);
   assign inst_o        = r_inst;
   assign fpu_op_o      = r_inst[31:27];
   assign imm_op_o      = r_imm_op;
   assign rd_we_o       = r_rd_we;
   assign frd_we_o      = r_frd_we;
   assign illegal_o     = r_illegal;
   assign fpu_timeout_o = r_timeout;

endmodule

// File: tb/tb_inst_seq_ctrl.sv
// Scoreboard bench for inst_seq_ctrl: stimulus pushes expected per-instruction outcomes,
// a monitor accumulates what each instruction did until ready returns and compares.
module tb_inst_seq_ctrl;

   localparam int unsigned FPU_TIMEOUT = 8;
   localparam int unsigned CNT_W       = 4;

   logic        clk_i = 1'b0;
   logic        rst_ni;
   logic        inst_valid_i;
   logic [31:0] inst_i;
   logic        inst_ready_o;
   logic [31:0] inst_o;
   logic [2:0]  imm_op_o;
   logic        fpu_req_o;
   logic [4:0]  fpu_op_o;
   logic        fpu_ack_i;
   logic        fpu_done_i;
   logic        rd_we_o;
   logic        frd_we_o;
   logic        illegal_o;
   logic        fpu_timeout_o;

   typedef struct {
      string      name;
      logic [2:0] imm;
      int         rd;
      int         frd;
      int         ill;
      int         to;
      int         lat;
      int         req;
      logic [4:0] op;
   } exp_t;

   exp_t exp_q[$];
   int   n_cmp  = 0;
   int   n_fail = 0;
   int   fpu_ack_dly  = -1;
   int   fpu_done_dly = -1;

   always #5 clk_i = ~clk_i;

   inst_seq_ctrl #(
      .FPU_TIMEOUT(FPU_TIMEOUT),
      .CNT_W      (CNT_W)
   ) dut (
      .clk_i        (clk_i),
      .rst_ni       (rst_ni),
      .inst_valid_i (inst_valid_i),
      .inst_i       (inst_i),
      .inst_ready_o (inst_ready_o),
      .inst_o       (inst_o),
      .imm_op_o     (imm_op_o),
      .fpu_req_o    (fpu_req_o),
      .fpu_op_o     (fpu_op_o),
      .fpu_ack_i    (fpu_ack_i),
      .fpu_done_i   (fpu_done_i),
      .rd_we_o      (rd_we_o),
      .frd_we_o     (frd_we_o),
      .illegal_o    (illegal_o),
      .fpu_timeout_o(fpu_timeout_o)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic finish_run();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   endtask

   function automatic exp_t mk(input logic [2:0] imm, input int rd, input int frd, input int ill,
                               input int to, input int lat, input int req, input logic [4:0] op);
      exp_t e;
      e.name = "";
      e.imm  = imm;
      e.rd   = rd;
      e.frd  = frd;
      e.ill  = ill;
      e.to   = to;
      e.lat  = lat;
      e.req  = req;
      e.op   = op;
      return e;
   endfunction

   task automatic check_idle_outputs(input string tag);
      check({tag, ".ready"},   {31'd0, inst_ready_o},  32'd1);
      check({tag, ".inst"},    inst_o,                 32'd0);
      check({tag, ".imm"},     {29'd0, imm_op_o},      32'd5);
      check({tag, ".fpu_op"},  {27'd0, fpu_op_o},      32'd0);
      check({tag, ".req"},     {31'd0, fpu_req_o},     32'd0);
      check({tag, ".rd_we"},   {31'd0, rd_we_o},       32'd0);
      check({tag, ".frd_we"},  {31'd0, frd_we_o},      32'd0);
      check({tag, ".illegal"}, {31'd0, illegal_o},     32'd0);
      check({tag, ".timeout"}, {31'd0, fpu_timeout_o}, 32'd0);
   endtask

   // Drive one instruction; the handshake wait is bounded.
   task automatic send(input string name, input logic [31:0] inst, input int ack_dly,
                       input int done_dly, input exp_t e);
      int budget;
      e.name = name;
      exp_q.push_back(e);
      inst_valid_i = 1'b1;
      inst_i       = inst;
      budget       = 0;
      forever begin
         @(negedge clk_i);
         if (inst_ready_o) break;
         budget++;
         if (budget > 100) begin
            n_cmp++;
            n_fail++;
            $display("FAIL %s.handshake: ready never seen within 100 cycles", name);
            finish_run();
         end
      end
      @(posedge clk_i);
      #1;
      fpu_ack_dly  = ack_dly;
      fpu_done_dly = done_dly;
      inst_valid_i = 1'b0;
      inst_i       = 32'd0;
   endtask

   // FPU model: ack/done asserted a programmed number of cycles after the request first appears.
   initial begin : fpu_model
      bit in_fp;
      int c;
      in_fp      = 1'b0;
      c          = 0;
      fpu_ack_i  = 1'b0;
      fpu_done_i = 1'b0;
      forever begin
         @(negedge clk_i);
         if (!rst_ni || inst_ready_o) begin
            in_fp = 1'b0;
         end else if (!in_fp && fpu_req_o) begin
            in_fp = 1'b1;
            c     = 0;
         end else if (in_fp) begin
            c++;
         end
         fpu_ack_i  = in_fp && (c == fpu_ack_dly);
         fpu_done_i = in_fp && (c == fpu_done_dly);
      end
   end

   initial begin : monitor
      bit         busy;
      int         m_lat, m_rd, m_frd, m_ill, m_to, m_req;
      logic [4:0] m_op;
      exp_t       e;
      busy = 1'b0;
      forever begin
         @(negedge clk_i);
         if (busy) begin
            m_lat++;
            if (rd_we_o)       m_rd++;
            if (frd_we_o)      m_frd++;
            if (illegal_o)     m_ill++;
            if (fpu_timeout_o) m_to++;
            if (fpu_req_o) begin
               m_req++;
               m_op = fpu_op_o;
            end
            if (inst_ready_o) begin
               busy = 1'b0;
               if (exp_q.size() == 0) begin
                  check("unexpected_retire", 32'd1, 32'd0);
               end else begin
                  e = exp_q.pop_front();
                  check({e.name, ".lat"},     m_lat,            e.lat);
                  check({e.name, ".imm"},     {29'd0, imm_op_o}, {29'd0, e.imm});
                  check({e.name, ".rd_we"},   m_rd,             e.rd);
                  check({e.name, ".frd_we"},  m_frd,            e.frd);
                  check({e.name, ".illegal"}, m_ill,            e.ill);
                  check({e.name, ".timeout"}, m_to,             e.to);
                  check({e.name, ".req_cyc"}, m_req,            e.req);
                  check({e.name, ".fpu_op"},  {27'd0, m_op},    {27'd0, e.op});
               end
            end
         end else if (rd_we_o | frd_we_o | illegal_o | fpu_timeout_o | fpu_req_o) begin
            check("idle_pulses", {27'd0, rd_we_o, frd_we_o, illegal_o, fpu_timeout_o, fpu_req_o}, 32'd0);
         end
         if (!busy && rst_ni && inst_valid_i && inst_ready_o) begin
            busy  = 1'b1;
            m_lat = 0;
            m_rd  = 0;
            m_frd = 0;
            m_ill = 0;
            m_to  = 0;
            m_req = 0;
            m_op  = 5'd0;
         end
      end
   end

   initial begin : stimulus
      int budget;
      rst_ni       = 1'b0;
      inst_valid_i = 1'b0;
      inst_i       = 32'd0;
      repeat (3) @(posedge clk_i);
      #1;
      check_idle_outputs("in_reset");
      rst_ni = 1'b1;
      @(posedge clk_i);
      #1;
      check_idle_outputs("after_reset");

      send("addi_x5",  32'h00700293,                                            -1, -1, mk(3'b000, 1, 0, 0, 0, 3, 0, 5'd0));
      send("sw",       {7'd0, 5'd5, 5'd2, 3'b010, 5'd4, 7'b0100011},             -1, -1, mk(3'b001, 0, 0, 0, 0, 3, 0, 5'd0));
      send("beq",      {7'd0, 5'd2, 5'd1, 3'b000, 5'd8, 7'b1100011},             -1, -1, mk(3'b010, 0, 0, 0, 0, 3, 0, 5'd0));
      send("lui",      {20'h12345, 5'd6, 7'b0110111},                            -1, -1, mk(3'b011, 1, 0, 0, 0, 3, 0, 5'd0));
      send("jal",      {20'h00100, 5'd1, 7'b1101111},                            -1, -1, mk(3'b100, 1, 0, 0, 0, 3, 0, 5'd0));
      send("add",      {7'd0, 5'd6, 5'd5, 3'b000, 5'd7, 7'b0110011},             -1, -1, mk(3'b101, 1, 0, 0, 0, 3, 0, 5'd0));
      send("jalr",     {12'd0, 5'd1, 3'b000, 5'd1, 7'b1100111},                  -1, -1, mk(3'b000, 1, 0, 0, 0, 3, 0, 5'd0));
      send("auipc",    {20'h00010, 5'd3, 7'b0010111},                            -1, -1, mk(3'b011, 1, 0, 0, 0, 3, 0, 5'd0));
      send("lw",       {12'd8, 5'd2, 3'b010, 5'd4, 7'b0000011},                  -1, -1, mk(3'b000, 1, 0, 0, 0, 3, 0, 5'd0));
      send("flw",      {12'd4, 5'd2, 3'b010, 5'd2, 7'b0000111},                  -1, -1, mk(3'b000, 0, 1, 0, 0, 3, 0, 5'd0));
      send("fsw",      {7'd0, 5'd2, 5'd2, 3'b010, 5'd8, 7'b0100111},             -1, -1, mk(3'b001, 0, 0, 0, 0, 3, 0, 5'd0));
      send("fadd",     {7'b0000000, 5'd3, 5'd2, 3'b000, 5'd1, 7'b1010011},        3,  5, mk(3'b101, 0, 1, 0, 0, 9, 4, 5'b00000));
      send("fcvt_w",   {7'b1100000, 5'd0, 5'd1, 3'b111, 5'd10, 7'b1010011},       0,  0, mk(3'b101, 1, 0, 0, 0, 4, 1, 5'b11000));
      send("feq_x0",   {7'b1010000, 5'd2, 5'd1, 3'b010, 5'd0, 7'b1010011},        1,  2, mk(3'b101, 0, 0, 0, 0, 6, 2, 5'b10100));
      send("fmul_to",  {7'b0001000, 5'd3, 5'd2, 3'b000, 5'd4, 7'b1010011},       -1, -1, mk(3'b101, 0, 0, 0, 1, 10, 8, 5'b00010));
      send("fdiv_edge",{7'b0001100, 5'd3, 5'd2, 3'b000, 5'd5, 7'b1010011},        0,  7, mk(3'b101, 0, 1, 0, 0, 11, 1, 5'b00011));
      send("addi_x0",  {12'd1, 5'd0, 3'b000, 5'd0, 7'b0010011},                  -1, -1, mk(3'b000, 0, 0, 0, 0, 3, 0, 5'd0));
      send("illegal",  {25'd0, 7'b1111111},                                      -1, -1, mk(3'b101, 0, 0, 1, 0, 2, 0, 5'd0));
      send("addi_x5b", 32'h00700293,                                            -1, -1, mk(3'b000, 1, 0, 0, 0, 3, 0, 5'd0));

      // Reset while the FPU operation sits in FPU_WAIT: nothing retires except the abort.
      send("fadd_rst", {7'b0000000, 5'd3, 5'd2, 3'b000, 5'd1, 7'b1010011},        1, -1, mk(3'b101, 0, 0, 0, 0, 5, 2, 5'b00000));
      repeat (4) @(posedge clk_i);
      #1;
      rst_ni = 1'b0;
      #1;
      check_idle_outputs("mid_reset");
      repeat (2) @(posedge clk_i);
      #1;
      rst_ni = 1'b1;
      send("addi_post",32'h00700293,                                            -1, -1, mk(3'b000, 1, 0, 0, 0, 3, 0, 5'd0));

      budget = 0;
      while (exp_q.size() != 0 && budget < 100) begin
         @(negedge clk_i);
         budget++;
      end
      if (exp_q.size() != 0) begin
         n_cmp++;
         n_fail++;
         $display("FAIL drain: %0d expected instructions never retired", exp_q.size());
      end
      repeat (3) @(negedge clk_i);
      finish_run();
   end

endmodule

// File: doc/inst_seq_ctrl.md
# inst_seq_ctrl

Multi-cycle instruction sequencer for the scalar RV32F core. It accepts one instruction per fetch handshake and classifies it by opcode. It drives the 3-bit immediate-format select consumed by the immediate generator, sequences OP-FP instructions through the multi-cycle FPU with a request/acknowledge/done handshake and a timeout, and issues one-cycle register-file write enables at writeback.

## Interface
- `FPU_TIMEOUT`, default 64: maximum cycles spent in FPU_REQ+FPU_WAIT before abort; must be ≥2.
- `CNT_W`, default 7: width of the timeout counter; must satisfy 2^CNT_W > FPU_TIMEOUT.
- `clk_i` input 1: single clock; all state updates on the rising edge.
- `rst_ni` input 1: reset, asynchronous and active-low.
- `inst_valid_i` input 1: fetch presents an instruction.
- `inst_i` input 32: instruction word, sampled on handshake.
- `inst_ready_o` output 1: sequencer can accept; high only in IDLE.
- `inst_o` output 32: latched instruction, stable from DEC through WB.
- `imm_op_o` output 3: immediate format select. 000 I, 001 S, 010 B, 011 U, 100 J, 101 R/none.
- `fpu_req_o` output 1: FPU operation request.
- `fpu_op_o` output 5: `inst_o[31:27]` (funct5), valid while `fpu_req_o` is high.
- `fpu_ack_i` input 1: FPU accepted the request.
- `fpu_done_i` input 1: FPU result ready (one-cycle pulse).
- `rd_we_o` output 1: integer register-file write pulse.
- `frd_we_o` output 1: FP register-file write pulse.
- `illegal_o` output 1: one-cycle pulse for an unsupported opcode.
- `fpu_timeout_o` output 1: one-cycle pulse on FPU abort.

## Operation
- States: IDLE, DEC, FPU_REQ, FPU_WAIT, WB.
- IDLE: `inst_ready_o`=1. On `inst_valid_i`, latch `inst_i` into `inst_o` and go to DEC.
- DEC, one cycle: `imm_op_o` is registered from opcode `inst_o[6:0]`:
  - 0010011, 0000011, 1100111, 0000111 → 000
  - 0100011, 0100111 → 001
  - 1100011 → 010
  - 0110111, 0010111 → 011
  - 1101111 → 100
  - 0110011, 1010011 → 101
  - Any other opcode → 101, pulse `illegal_o`, return to IDLE with no writeback.
- DEC next state: opcode 1010011 goes to FPU_REQ and clears the timeout counter. All other legal opcodes go to WB.
- FPU_REQ: hold `fpu_req_o`=1 until `fpu_ack_i`, then go to FPU_WAIT. `fpu_req_o` drops in the cycle after ack is sampled.
- FPU_WAIT: on `fpu_done_i`, go to WB. A `fpu_done_i` seen in FPU_REQ (same cycle as ack) goes straight to WB.
- Timeout counter: increments every cycle in FPU_REQ and FPU_WAIT. When it reaches FPU_TIMEOUT-1 with no completing event, pulse `fpu_timeout_o`, drop `fpu_req_o`, and return to IDLE with no writeback. Completion wins when it coincides with expiry.
- WB, one cycle, pulses at most one write enable:
  - `rd_we_o`: opcodes 0010011, 0000011, 1100111, 0110111, 0010111, 1101111, 0110011; also 1010011 with funct5 ∈ {10100, 11000, 11100}. Suppressed when `inst_o[11:7]`=0.
  - `frd_we_o`: opcode 0000111; also 1010011 with any other funct5.
  - No write: store, FSW, branch.
- `imm_op_o` and `inst_o` hold their values until the next DEC or handshake.
- Reset mid-operation: immediate return to IDLE. Any outstanding FPU request is abandoned; no pulse is emitted.

## Timing
- Reset values: `inst_ready_o`=1 (IDLE), `inst_o`=0, `imm_op_o`=101, `fpu_op_o`=0. `fpu_req_o`, `rd_we_o`, `frd_we_o`, `illegal_o`, `fpu_timeout_o` all 0.
- All outputs are registered or are pure state decodes. There are no combinational input→output paths, except that `fpu_op_o` is a slice of `inst_o`.
- Integer instruction, handshake at cycle T: DEC at T+1, `imm_op_o` valid from T+2, write pulse at T+2, `inst_ready_o` high again at T+3.
- FP instruction with ack at cycle A and done at cycle D: `fpu_req_o` high from T+2 through A, write pulse at D+1, ready at D+2.
- Illegal instruction: `illegal_o` at T+2, ready at T+2.

## Test plan
- Reset, then `addi x5,x0,7` (0x00700293) handshake at T → `imm_op_o`=000 at T+2, `rd_we_o`=1 at T+2 only, `inst_ready_o`=1 at T+3.
- `sw`, `beq`, `lui`, `jal`, `add` back-to-back → `imm_op_o` = 001, 010, 011, 100, 101. Only `lui`, `jal`, `add` pulse `rd_we_o`. Throughput is 3 cycles each.
- `fadd.s` with ack 3 cycles and done 5 cycles after request → `fpu_op_o`=00000, `frd_we_o` pulses one cycle after done. `fcvt.w.s` with rd=x10 pulses `rd_we_o` instead.
- FPU never acks, FPU_TIMEOUT=8 → `fpu_timeout_o` pulses after 8 request cycles, no write pulse, `inst_ready_o`=1 on the next cycle.
- Opcode 1111111 → `illegal_o` pulse, `imm_op_o`=101, no write, accepted again 2 cycles after handshake. `addi x0,…` → no `rd_we_o`.
- `rst_ni` asserted during FPU_WAIT → all pulses 0 and state IDLE immediately. After release, the next instruction proceeds normally.
